// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU pipeline control: opcodes, mux/forward encodings and
// small opcode classification helpers.
package cpu_pkg;

    typedef enum logic [4:0] {
        OpMv    = 5'd0,
        OpAdd   = 5'd1,
        OpSub   = 5'd2,
        OpCmp   = 5'd3,
        OpLd    = 5'd4,
        OpSt    = 5'd5,
        OpMvi   = 5'd6,
        OpAddi  = 5'd7,
        OpSubi  = 5'd8,
        OpCmpi  = 5'd9,
        OpMvhi  = 5'd10,
        OpJr    = 5'd11,
        OpJzr   = 5'd12,
        OpJnr   = 5'd13,
        OpCallr = 5'd14,
        OpJ     = 5'd15,
        OpJz    = 5'd16,
        OpJn    = 5'd17,
        OpCall  = 5'd18
    } opcode_t;

    localparam logic [2:0] SelARx    = 3'd0;
    localparam logic [2:0] SelAPc    = 3'd2;
    localparam logic [2:0] SelAImm8  = 3'd3;
    localparam logic [2:0] SelAImmHi = 3'd4;

    localparam logic [2:0] SelBRy    = 3'd0;
    localparam logic [2:0] SelBImm8  = 3'd1;
    localparam logic [2:0] SelBImm11 = 3'd2;
    localparam logic [2:0] SelBZero  = 3'd3;

    localparam logic [1:0] FwdReg = 2'd0;
    localparam logic [1:0] FwdAlu = 2'd1;
    localparam logic [1:0] FwdMem = 2'd2;

    function automatic logic writes_reg(opcode_t op);
        case (op)
            OpMv, OpAdd, OpSub, OpLd, OpMvi, OpAddi, OpSubi, OpMvhi: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_call(opcode_t op);
        return (op == OpCall) || (op == OpCallr);
    endfunction

    function automatic logic sets_flags(opcode_t op);
        case (op)
            OpAdd, OpSub, OpCmp, OpAddi, OpSubi, OpCmpi: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rx(opcode_t op);
        case (op)
            OpAdd, OpSub, OpCmp, OpSt, OpAddi, OpSubi, OpCmpi,
            OpJr, OpJzr, OpJnr, OpCallr: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_ry(opcode_t op);
        case (op)
            OpMv, OpAdd, OpSub, OpCmp, OpLd, OpSt: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_hazard_unit.sv
// RAW hazard detection against the execute stage: forwarding selects, or a one-cycle
// stall request when forwarding is disabled.
module cpu_hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned RW     = 3,
    parameter int unsigned FWD_EN = 1
) (
    input  logic          rd_use,
    input  opcode_t       rd_op,
    input  logic [RW-1:0] rd_rx,
    input  logic [RW-1:0] rd_ry,
    input  logic          ex_valid,
    input  opcode_t       ex_op,
    input  logic [RW-1:0] ex_rx,
    input  logic          wait_busy,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          stall_req
);

    logic          prod;
    logic [RW-1:0] dst;
    logic [1:0]    src;
    logic          hit_a;
    logic          hit_b;

    always_comb begin
        // A call's R7 write is treated like an ALU result for hazard purposes.
        prod  = ex_valid & ~wait_busy & (writes_reg(ex_op) | is_call(ex_op));
        dst   = is_call(ex_op) ? RW'(7) : ex_rx;
        src   = (ex_op == OpLd) ? FwdMem : FwdAlu;
        hit_a = rd_use & prod & uses_rx(rd_op) & (rd_rx == dst);
        hit_b = rd_use & prod & uses_ry(rd_op) & (rd_ry == dst);

        fwd_a     = FwdReg;
        fwd_b     = FwdReg;
        stall_req = 1'b0;
        if (FWD_EN != 0) begin
            fwd_a = hit_a ? src : FwdReg;
            fwd_b = hit_b ? src : FwdReg;
        end else begin
            stall_req = hit_a | hit_b;
        end
    end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Two-stage pipelined control for the 16-bit lab CPU: read-stage decode, execute-stage
// write-back control, N/Z flags, branch squash, load wait and RAW handling.
module cpu_pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned OPW     = 5,
    parameter int unsigned RW      = 3,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned FWD_EN  = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_rd_valid,
    input  logic [OPW-1:0] i_rd_opcode,
    input  logic [RW-1:0]  i_rd_rx,
    input  logic [RW-1:0]  i_rd_ry,
    input  logic           i_alu_n,
    input  logic           i_alu_z,
    output logic           o_pc_rd,
    output logic           o_stall,
    output logic [2:0]     o_sel_a,
    output logic [2:0]     o_sel_b,
    output logic           o_addsub,
    output logic [1:0]     o_fwd_a,
    output logic [1:0]     o_fwd_b,
    output logic           o_ldpc,
    output logic           o_ldpc_7,
    output logic           o_mem_rd,
    output logic           o_mem_wr,
    output logic           o_ldr,
    output logic           o_ld_mem_rd,
    output logic [RW-1:0]  o_wr_idx,
    output logic           o_n,
    output logic           o_z
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    opcode_t       rd_op;
    logic          run_q, kill_q, ex_valid_q, n_q, z_q;
    opcode_t       ex_op_q;
    logic [RW-1:0] ex_rx_q;
    logic [CW-1:0] wait_q;
    logic          wait_busy, rd_use, raw_stall, stall, eff, set_flags;

    assign rd_op     = opcode_t'(i_rd_opcode);
    assign wait_busy = (wait_q != '0);
    assign rd_use    = run_q & i_rd_valid & ~kill_q;
    assign stall     = wait_busy | raw_stall;
    assign eff       = rd_use & ~stall;

    cpu_hazard_unit #(
        .RW     (RW),
        .FWD_EN (FWD_EN)
    ) u_hazard (
        .rd_use    (rd_use),
        .rd_op     (rd_op),
        .rd_rx     (i_rd_rx),
        .rd_ry     (i_rd_ry),
        .ex_valid  (ex_valid_q),
        .ex_op     (ex_op_q),
        .ex_rx     (ex_rx_q),
        .wait_busy (wait_busy),
        .fwd_a     (o_fwd_a),
        .fwd_b     (o_fwd_b),
        .stall_req (raw_stall)
    );

    always_comb begin
        o_sel_a   = SelARx;
        o_sel_b   = SelBRy;
        o_addsub  = 1'b0;
        o_ldpc    = 1'b0;
        o_ldpc_7  = 1'b0;
        o_mem_rd  = 1'b0;
        o_mem_wr  = 1'b0;
        set_flags = eff & sets_flags(rd_op);
        if (eff) begin
            case (rd_op)
                OpMv:          o_sel_a = SelAImm8;  // mv encodes a zero imm8
                OpSub, OpCmp:  o_addsub = 1'b1;
                OpLd:          begin o_sel_a = SelAImm8; o_mem_rd = 1'b1; end
                OpSt:          begin o_sel_a = SelAImm8; o_mem_wr = 1'b1; end
                OpMvi:         begin o_sel_a = SelAImm8; o_sel_b = SelBZero; end
                OpAddi:        o_sel_b = SelBImm8;
                OpSubi, OpCmpi: begin o_sel_b = SelBImm8; o_addsub = 1'b1; end
                OpMvhi:        begin o_sel_a = SelAImmHi; o_sel_b = SelBZero; end
                OpJr:          begin o_sel_b = SelBZero; o_ldpc = 1'b1; end
                OpJzr:         begin o_sel_b = SelBZero; o_ldpc = z_q; end
                OpJnr:         begin o_sel_b = SelBZero; o_ldpc = n_q; end
                OpCallr:       begin o_sel_b = SelBZero; o_ldpc = 1'b1; o_ldpc_7 = 1'b1; end
                OpJ:           begin o_sel_a = SelAPc; o_sel_b = SelBImm11; o_ldpc = 1'b1; end
                OpJz:          begin o_sel_a = SelAPc; o_sel_b = SelBImm11; o_ldpc = z_q; end
                OpJn:          begin o_sel_a = SelAPc; o_sel_b = SelBImm11; o_ldpc = n_q; end
                OpCall: begin
                    o_sel_a  = SelAPc;
                    o_sel_b  = SelBImm11;
                    o_ldpc   = 1'b1;
                    o_ldpc_7 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pc_rd     = run_q & ~stall;
    assign o_stall     = stall;
    assign o_ldr       = ex_valid_q & writes_reg(ex_op_q) & ~wait_busy;
    assign o_ld_mem_rd = ex_valid_q & (ex_op_q == OpLd) & ~wait_busy;
    assign o_wr_idx    = ex_rx_q;
    assign o_n         = n_q;
    assign o_z         = z_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            kill_q     <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= OpMv;
            ex_rx_q    <= '0;
            wait_q     <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            kill_q <= o_ldpc;
            if (set_flags) begin
                n_q <= i_alu_n;
                z_q <= i_alu_z;
            end
            if (wait_busy) begin
                wait_q <= wait_q - CW'(1);
            end else if (!kill_q) begin
                // During a squash the branch stays in execute so a call's R7 remains visible.
                ex_valid_q <= eff;
                ex_op_q    <= rd_op;
                ex_rx_q    <= i_rd_rx;
                if (MEM_LAT > 1 && eff && rd_op == OpLd) wait_q <= CW'(MEM_LAT - 1);
            end
        end
    end

endmodule

// File: doc/cpu_pipe_ctrl.md
Name: cpu_pipe_ctrl

Overview:
Parametrised pipelined control unit for the 16-bit lab CPU, replacing the purely combinational read/write-stage decoder.
- Decodes the read-stage opcode and owns the execute-stage opcode/destination register and its valid bit.
- Owns the N/Z flag register and the taken-branch squash.
- Adds RAW forwarding, multi-cycle load wait and stall control.
- Sits between the instruction register (IR) and the datapath muxes, ALU, register file and data memory.

Parameters:
OPW, 5, opcode width; encodings come from the shared package.
RW, 3, register index width.
MEM_LAT, 1, data-memory read latency in cycles (>=1).
FWD_EN, 1, 1 = forward on RAW hazards; 0 = stall one cycle instead.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
i_rd_valid  in  1  IR holds a valid instruction.
i_rd_opcode  in  OPW  read-stage opcode.
i_rd_rx  in  RW  read-stage Rx index.
i_rd_ry  in  RW  read-stage Ry index.
i_alu_n  in  1  ALU result negative.
i_alu_z  in  1  ALU result zero.
o_pc_rd  out  1  fetch enable; low holds PC and IR.
o_stall  out  1  pipeline stall indicator.
o_sel_a  out  3  ALU A-mux select (0 Rx, 2 PC, 3 s_ext imm8, 4 imm8<<8).
o_sel_b  out  3  ALU B-mux select (0 Ry, 1 s_ext imm8, 2 2*s_ext imm11, 3 zero).
o_addsub  out  1  0 add, 1 subtract.
o_fwd_a  out  2  operand-A source: 0 regfile, 1 execute ALU result, 2 memory read data.
o_fwd_b  out  2  operand-B source, same encoding.
o_ldpc  out  1  load PC from ALU.
o_ldpc_7  out  1  write return address to R7.
o_mem_rd  out  1  data-memory read.
o_mem_wr  out  1  data-memory write.
o_ldr  out  1  register-file write.
o_ld_mem_rd  out  1  write-back source is memory data.
o_wr_idx  out  RW  register-file write index.
o_n  out  1  N flag register.
o_z  out  1  Z flag register.

Behaviour:
- Reset (reset low, async):
  - ex_valid, kill, wait counter, n, z all clear.
  - Every output is 0, including o_pc_rd.
  - First rising edge after release: o_pc_rd=1.
- Read-stage instruction is effective when i_rd_valid & ~kill & ~o_stall.
  - Decode is identical to the existing ISA table: mv/add/sub/cmp/ld/st/mvi/addi/subi/cmpi/mvhi/jr/jzr/jnr/callr/j/jz/jn/call.
  - Non-effective instructions drive o_sel_a/o_sel_b/o_addsub to 0 and keep o_ldpc, o_ldpc_7, o_mem_rd, o_mem_wr low. The flag register is not loaded.
  - Unknown opcodes behave as a NOP and still advance.
- Flags:
  - Effective add/sub/cmp/addi/subi/cmpi loads n<=i_alu_n, z<=i_alu_z at the clock edge.
  - jz/jzr/jn/jnr test the registered flags.
- Taken branch (o_ldpc=1): kill<=1 for exactly one cycle, squashing the wrong-path IR.
  - A squashed instruction writes nothing and never enters execute as valid.
- Execute stage:
  - On advance: ex_valid<=effective, ex_op<=i_rd_opcode, ex_rx<=i_rd_rx.
  - o_ldr=1 when ex_valid and ex_op is mv/add/sub/ld/mvi/addi/subi/mvhi. o_wr_idx=ex_rx.
  - cmp/cmpi/st/jumps never write the register file. call/callr write R7 only via o_ldpc_7.
- Load wait: ld in execute with MEM_LAT>1 loads counter MEM_LAT-1.
  - While counter!=0: o_stall=1, o_pc_rd=0, o_ldr=0, execute and IR hold; counter decrements each cycle.
  - o_ldr and o_ld_mem_rd assert together in the cycle counter==0.
- RAW hazard: effective read-stage source (Rx and/or Ry as used by the opcode) equals ex_rx while execute will assert o_ldr.
  - FWD_EN=1: o_fwd_x=1 for an ALU producer, 2 for a load producer. Valid only in the write cycle, so it coincides with load-wait release.
  - FWD_EN=0: one stall cycle. IR holds and execute becomes a bubble after its write; the instruction re-issues next cycle with o_fwd=0.
- Priority: reset > load wait > RAW stall > kill > normal.
  - A taken branch is never issued during a stall.
- R7 written by call is a hazard source for a following jr/mv reading R7; treat it as an ALU producer.

Decomposition:
- Package cpu_pkg holds the opcode localparams as a typedef enum logic [4:0] opcode_t, the sel_a/sel_b/fwd encodings as named constants, and a function writes_reg(opcode_t).
- One sub-module, cpu_hazard_unit: RAW compare, forwarding selects and stall request; purely combinational with its inputs registered by the parent.

Test Plan:
- Reset mid-load (MEM_LAT=3, reset low at wait count 1) -> all outputs 0 immediately; counter 0, o_pc_rd=1 one cycle after release.
- addi R1,5 then add R2,R1, FWD_EN=1 -> add sees o_fwd_b=1, no stall. FWD_EN=0 -> one cycle o_stall=1, then o_fwd_b=0.
- ld R3,[R4] with MEM_LAT=3 -> o_stall high 2 cycles, then o_ldr=o_ld_mem_rd=1, o_wr_idx=3. Following add R5,R3 gets o_fwd_b=2.
- cmpi R0,0 with R0=0, then jz -> z=1, o_ldpc=1. Next IR is squashed: o_ldr=0 and no flag change on the following cycle.
- jn with n=0 -> o_ldpc=0, no kill, next instruction executes normally.
- call -> o_ldpc=o_ldpc_7=1, kill one cycle. Following jr R7 -> forwarding from R7 (o_fwd_a=1).
